// File: rtl/load_align_if.sv
// load_align_if: load request, memory read port and load result bundle
interface load_align_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  load_req;
   logic [2:0]            load_funct3;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic                  mem_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_resp;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_done;
   logic                  load_fault;
   logic                  busy;
   modport master (
      output load_req, load_funct3, load_addr, mem_resp, mem_rdata,
      input  mem_read, mem_address, load_data, load_done, load_fault, busy
   );
   modport slave (
      input  load_req, load_funct3, load_addr, mem_resp, mem_rdata,
      output mem_read, mem_address, load_data, load_done, load_fault, busy
   );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: RV32I load handshake with byte/halfword extraction and extension
module load_align_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   load_align_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;
   state_t                state, state_n;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q, data_n;
   logic                  legal;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end
   // request legality: known funct3 and natural alignment for the access size
   always_comb begin
      legal = (bus.load_funct3 == 3'b000) || (bus.load_funct3 == 3'b100) ||
              (((bus.load_funct3 == 3'b001) || (bus.load_funct3 == 3'b101)) && !bus.load_addr[0]) ||
              ((bus.load_funct3 == 3'b010) && (bus.load_addr[1:0] == 2'b00));
   end
   // next-state logic; requests outside IDLE and responses outside WAIT are ignored
   always_comb begin
      state_n = (state == S_IDLE) ? (bus.load_req ? (legal ? S_WAIT : S_FAULT) : S_IDLE) :
                (state == S_WAIT) ? (bus.mem_resp ? S_DONE : S_WAIT) : S_IDLE;
   end
   // capture request fields on acceptance and the extracted word on response
   always_ff @(posedge clk) begin
      if (rst) begin
         funct3_q <= '0;
         off_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         if (state == S_IDLE && bus.load_req) begin
            funct3_q <= bus.load_funct3;
            off_q    <= bus.load_addr[1:0];
            if (legal) addr_q <= {bus.load_addr[ADDR_WIDTH-1:2], 2'b00};
         end
         if (state == S_WAIT && bus.mem_resp) data_q <= data_n;
      end
   end
   // lane select and sign/zero extension of the returned word
   always_comb begin
      byte_v = bus.mem_rdata[{off_q, 3'b000} +: 8];
      half_v = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      data_n = funct3_q[1] ? bus.mem_rdata :
               funct3_q[0] ? {{(DATA_WIDTH-16){half_v[15] & ~funct3_q[2]}}, half_v} :
                             {{(DATA_WIDTH-8){byte_v[7] & ~funct3_q[2]}}, byte_v};
   end
   // outputs decoded from state and the capture registers
   always_comb begin
      bus.mem_read    = state == S_WAIT;
      bus.load_done   = state == S_DONE;
      bus.load_fault  = state == S_FAULT;
      bus.busy        = state != S_IDLE;
      bus.mem_address = addr_q;
      bus.load_data   = data_q;
   end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed scoreboard bench for load_align_unit
module tb_load_align_unit;
   logic clk = 0;
   logic rst = 1;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   logic [31:0] last_data = 0;
   logic [31:0] sb[$];
   load_align_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc();
   load_align_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(ifc));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // scoreboard: every load_done pops one expected value
   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.load_done) begin
            done_cnt++;
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_done observed=%h expected=none", ifc.load_data);
            end
            if (sb.size() != 0) chk("load_data", ifc.load_data, sb.pop_front());
         end
         chk("done_fault_excl", {31'b0, ifc.load_done & ifc.load_fault}, 32'b0);
      end
   end
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input int d, input bit inj, input logic [31:0] exp);
      int n;
      int start;
      n = 0;
      start = done_cnt;
      sb.push_back(exp);
      ifc.load_req = 1; ifc.load_funct3 = f3; ifc.load_addr = addr;
      tick();
      ifc.load_req = 0;
      chk("mem_address", ifc.mem_address, {addr[31:2], 2'b00});
      for (int i = 0; i < d; i++) begin
         if (ifc.mem_read) n++;
         ifc.load_req = inj && (i == 0);
         ifc.load_funct3 = 3'b000; ifc.load_addr = 32'h0000_5001;
         ifc.mem_resp = 1'b0;
         tick();
         ifc.load_req = 0;
         chk("addr_stable", ifc.mem_address, {addr[31:2], 2'b00});
      end
      if (ifc.mem_read) n++;
      ifc.mem_resp = 1; ifc.mem_rdata = rdata;
      tick();
      ifc.mem_resp = 0; ifc.mem_rdata = $urandom;
      chk("mem_read_cycles", n, d + 1);
      chk("mem_read_drop", {31'b0, ifc.mem_read}, 32'b0);
      chk("done_at_resp_plus1", {31'b0, ifc.load_done}, 32'b1);
      tick();
      chk("done_pulse_end", {31'b0, ifc.load_done}, 32'b0);
      chk("busy_after_done", {31'b0, ifc.busy}, 32'b0);
      chk("done_count", done_cnt - start, 1);
      last_data = exp;
   endtask
   task automatic do_fault(input logic [2:0] f3, input logic [31:0] addr);
      ifc.load_req = 1; ifc.load_funct3 = f3; ifc.load_addr = addr;
      tick();
      ifc.load_req = 0;
      chk("fault_pulse", {31'b0, ifc.load_fault}, 32'b1);
      chk("fault_no_read", {31'b0, ifc.mem_read}, 32'b0);
      chk("fault_busy", {31'b0, ifc.busy}, 32'b1);
      chk("fault_data_hold", ifc.load_data, last_data);
      tick();
      chk("fault_pulse_end", {31'b0, ifc.load_fault}, 32'b0);
      chk("fault_idle_read", {31'b0, ifc.mem_read}, 32'b0);
      chk("fault_idle_busy", {31'b0, ifc.busy}, 32'b0);
   endtask
   initial begin
      ifc.load_req = 0; ifc.load_funct3 = 0; ifc.load_addr = 0;
      ifc.mem_resp = 0; ifc.mem_rdata = 0;
      tick(); tick();
      rst = 0;
      chk("rst_mem_read", {31'b0, ifc.mem_read}, 32'b0);
      chk("rst_mem_address", ifc.mem_address, 32'h0);
      chk("rst_load_data", ifc.load_data, 32'h0);
      chk("rst_done", {31'b0, ifc.load_done}, 32'b0);
      chk("rst_fault", {31'b0, ifc.load_fault}, 32'b0);
      chk("rst_busy", {31'b0, ifc.busy}, 32'b0);
      do_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 1, 0, 32'hFFFF_FF80);
      do_load(3'b100, 32'h0000_1002, 32'h80FF_1234, 1, 0, 32'h0000_00FF);
      do_load(3'b101, 32'h0000_1002, 32'h80FF_1234, 1, 0, 32'h0000_80FF);
      do_load(3'b001, 32'h0000_1002, 32'h80FF_1234, 1, 0, 32'hFFFF_80FF);
      do_load(3'b000, 32'h0000_1000, 32'h80FF_1234, 0, 0, 32'h0000_0034);
      do_load(3'b100, 32'h0000_1001, 32'h80FF_1294, 0, 0, 32'h0000_0012);
      do_load(3'b001, 32'h0000_1000, 32'h1234_9ABC, 0, 0, 32'hFFFF_9ABC);
      do_load(3'b101, 32'h0000_1000, 32'h1234_9ABC, 0, 0, 32'h0000_9ABC);
      do_load(3'b001, 32'h0000_1002, 32'h7FFF_0000, 0, 0, 32'h0000_7FFF);
      do_load(3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 4, 0, 32'hDEAD_BEEF);
      do_load(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
      do_fault(3'b010, 32'h0000_2002);
      do_fault(3'b001, 32'h0000_2001);
      do_fault(3'b101, 32'h0000_2003);
      do_fault(3'b011, 32'h0000_3000);
      do_fault(3'b110, 32'h0000_3000);
      do_fault(3'b111, 32'h0000_3000);
      do_load(3'b010, 32'h0000_4000, 32'h0123_4567, 3, 1, 32'h0123_4567);
      tick();
      chk("inj_ignored_busy", {31'b0, ifc.busy}, 32'b0);
      chk("inj_ignored_read", {31'b0, ifc.mem_read}, 32'b0);
      ifc.mem_resp = 1; ifc.mem_rdata = 32'hFFFF_FFFF;
      tick();
      ifc.mem_resp = 0;
      chk("spur_resp_busy", {31'b0, ifc.busy}, 32'b0);
      chk("spur_resp_data", ifc.load_data, last_data);
      tick();
      chk("spur_resp_done", {31'b0, ifc.load_done}, 32'b0);
      ifc.load_req = 1; ifc.load_funct3 = 3'b010; ifc.load_addr = 32'h0000_6000;
      tick();
      ifc.load_req = 0;
      chk("pre_rst_read", {31'b0, ifc.mem_read}, 32'b1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("abort_read", {31'b0, ifc.mem_read}, 32'b0);
      chk("abort_busy", {31'b0, ifc.busy}, 32'b0);
      chk("abort_data", ifc.load_data, 32'h0);
      chk("abort_done", {31'b0, ifc.load_done}, 32'b0);
      chk("abort_addr", ifc.mem_address, 32'h0);
      last_data = 0;
      do_fault(3'b010, 32'h0000_6001);
      do_load(3'b010, 32'h0000_6000, 32'h89AB_CDEF, 2, 0, 32'h89AB_CDEF);
      tick();
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
